// File: rtl/rv32i_ex_pkg.sv
// Shared definitions for the RV32I execute stage: ALU op codes, forward selects,
// XLEN and the EX/MEM register layout.
package RV32I_definitions;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } aluOpT;

  typedef enum logic [1:0] {
    FWD_ID  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwdSelT;

  typedef struct packed {
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] rs2Data;
    logic [4:0]      rdAddress;
    logic            rdWrEn;
    logic [XLEN-1:0] branchDest;
    logic            pcSourceSel;
  } exMemT;

  // Branch codes compare Rs1 against Rs2 and never use the immediate.
  function automatic logic isBranchOp(input logic [3:0] op);
    return op >= 4'd10;
  endfunction

endpackage

// File: rtl/rv32i_ex_alu.sv
// Combinational RV32I ALU: arithmetic/logic result plus the branch condition
// selected by the op code.
module rv32i_alu
  import RV32I_definitions::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      op_i,
  output logic [XLEN-1:0] result_o,
  output logic            branchCond_o
);

  logic [4:0] shamt;
  logic       signedLt;
  logic       unsignedLt;
  logic       equal;

  assign shamt      = b_i[4:0];
  assign signedLt   = $signed(a_i) < $signed(b_i);
  assign unsignedLt = a_i < b_i;
  assign equal      = a_i == b_i;

  // Branch codes leave the result at zero and only raise the condition.
  always_comb begin
    result_o     = '0;
    branchCond_o = 1'b0;
    case (aluOpT'(op_i))
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, signedLt};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, unsignedLt};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_BEQ:  branchCond_o = equal;
      ALU_BNE:  branchCond_o = !equal;
      ALU_BLT:  branchCond_o = signedLt;
      ALU_BGE:  branchCond_o = !signedLt;
      ALU_BLTU: branchCond_o = unsignedLt;
      ALU_BGEU: branchCond_o = !unsignedLt;
      default:  ;
    endcase
  end

endmodule

// File: rtl/rv32i_ex.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM
// register. Forwarding from MEM/WB is built only when RV32I_EX_FWD_EN is defined.
module rv32i_ex
  import RV32I_definitions::*;
(
  input  logic        Clk_100MHz,
  input  logic        Reset_n,
  input  logic [31:0] ID_PC,
  input  logic        ID_Rd_wr_en,
  input  logic        ID_ALU_source_sel,
  input  logic [3:0]  ID_ALU_op,
  input  logic [31:0] ID_Immediate,
  input  logic        ID_Branch_en,
  input  logic [4:0]  ID_Rd_address,
  input  logic [4:0]  ID_Rs1_address,
  input  logic [4:0]  ID_Rs2_address,
  input  logic [31:0] ID_Rs1_data,
  input  logic [31:0] ID_Rs2_data,
  input  logic [4:0]  MEM_Rd_address,
  input  logic        MEM_Rd_wr_en,
  input  logic [31:0] MEM_ALU_result,
  input  logic [4:0]  WB_Rd_address,
  input  logic        WB_wr_en,
  input  logic [31:0] WB_Rd_wr_data,
  input  logic        EX_stall,
  input  logic        EX_flush,
  output logic [31:0] EX_ALU_result,
  output logic [31:0] EX_Rs2_data,
  output logic [4:0]  EX_Rd_address,
  output logic        EX_Rd_wr_en,
  output logic [31:0] EX_PC_branch_dest,
  output logic        EX_PC_source_sel
);

  fwdSelT          rs1Sel;
  fwdSelT          rs2Sel;
  logic [XLEN-1:0] rs1Fwd;
  logic [XLEN-1:0] rs2Fwd;
  logic [XLEN-1:0] operandB;
  logic [XLEN-1:0] aluResult;
  logic            branchCond;
  exMemT           exMem_d;
  exMemT           exMem_q;

`ifdef RV32I_EX_FWD_EN
  // MEM is the younger producer so it wins over WB; x0 is hardwired and never forwarded.
  always_comb begin
    rs1Sel = FWD_ID;
    if (MEM_Rd_wr_en && (MEM_Rd_address == ID_Rs1_address) && (ID_Rs1_address != 5'd0))
      rs1Sel = FWD_MEM;
    else if (WB_wr_en && (WB_Rd_address == ID_Rs1_address) && (ID_Rs1_address != 5'd0))
      rs1Sel = FWD_WB;

    rs2Sel = FWD_ID;
    if (MEM_Rd_wr_en && (MEM_Rd_address == ID_Rs2_address) && (ID_Rs2_address != 5'd0))
      rs2Sel = FWD_MEM;
    else if (WB_wr_en && (WB_Rd_address == ID_Rs2_address) && (ID_Rs2_address != 5'd0))
      rs2Sel = FWD_WB;
  end
`else
  logic unusedFwd;
  assign unusedFwd = ^{ID_Rs1_address, ID_Rs2_address, MEM_Rd_address, MEM_Rd_wr_en,
                       MEM_ALU_result, WB_Rd_address, WB_wr_en, WB_Rd_wr_data};
  assign rs1Sel = FWD_ID;
  assign rs2Sel = FWD_ID;
`endif

  always_comb begin
    case (rs1Sel)
      FWD_MEM: rs1Fwd = MEM_ALU_result;
      FWD_WB:  rs1Fwd = WB_Rd_wr_data;
      default: rs1Fwd = ID_Rs1_data;
    endcase
    case (rs2Sel)
      FWD_MEM: rs2Fwd = MEM_ALU_result;
      FWD_WB:  rs2Fwd = WB_Rd_wr_data;
      default: rs2Fwd = ID_Rs2_data;
    endcase
  end

  assign operandB = (ID_ALU_source_sel && !isBranchOp(ID_ALU_op)) ? ID_Immediate : rs2Fwd;

  rv32i_alu u_alu (
    .a_i          (rs1Fwd),
    .b_i          (operandB),
    .op_i         (ID_ALU_op),
    .result_o     (aluResult),
    .branchCond_o (branchCond)
  );

  always_comb begin
    exMem_d             = '0;
    exMem_d.aluResult   = aluResult;
    exMem_d.rs2Data     = rs2Fwd;
    exMem_d.rdAddress   = ID_Rd_address;
    exMem_d.rdWrEn      = ID_Rd_wr_en;
    exMem_d.branchDest  = ID_PC + ID_Immediate;
    exMem_d.pcSourceSel = ID_Branch_en & branchCond;
  end

  // Flush beats stall so the hazard unit can kill an instruction even while MEM is held.
  always_ff @(posedge Clk_100MHz or negedge Reset_n) begin
    if (!Reset_n)
      exMem_q <= '0;
    else if (EX_flush)
      exMem_q <= '0;
    else if (!EX_stall)
      exMem_q <= exMem_d;
  end

  assign EX_ALU_result     = exMem_q.aluResult;
  assign EX_Rs2_data       = exMem_q.rs2Data;
  assign EX_Rd_address     = exMem_q.rdAddress;
  assign EX_Rd_wr_en       = exMem_q.rdWrEn;
  assign EX_PC_branch_dest = exMem_q.branchDest;
  assign EX_PC_source_sel  = exMem_q.pcSourceSel;

endmodule

// File: tb/tb_rv32i_ex.sv
// Self-checking bench for rv32i_ex: a reference model pushes expected EX/MEM
// contents into a scoreboard that is popped after each clock edge.
module tb_rv32i_ex;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        wrEn;
    logic [31:0] dest;
    logic        taken;
  } expT;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] idPc;
  logic        idRdWrEn;
  logic        idSrcSel;
  logic [3:0]  idOp;
  logic [31:0] idImm;
  logic        idBrEn;
  logic [4:0]  idRd;
  logic [4:0]  idRs1;
  logic [4:0]  idRs2;
  logic [31:0] idRs1Data;
  logic [31:0] idRs2Data;
  logic [4:0]  memRd;
  logic        memWr;
  logic [31:0] memRes;
  logic [4:0]  wbRd;
  logic        wbWr;
  logic [31:0] wbData;
  logic        exStall;
  logic        exFlush;
  logic [31:0] exAluResult;
  logic [31:0] exRs2Data;
  logic [4:0]  exRdAddress;
  logic        exRdWrEn;
  logic [31:0] exBranchDest;
  logic        exPcSourceSel;

  int   checkCount = 0;
  int   errorCount = 0;
  expT  scoreboard[$];
  expT  lastExp = '0;

  rv32i_ex dut (
    .Clk_100MHz        (clk),
    .Reset_n           (rstN),
    .ID_PC             (idPc),
    .ID_Rd_wr_en       (idRdWrEn),
    .ID_ALU_source_sel (idSrcSel),
    .ID_ALU_op         (idOp),
    .ID_Immediate      (idImm),
    .ID_Branch_en      (idBrEn),
    .ID_Rd_address     (idRd),
    .ID_Rs1_address    (idRs1),
    .ID_Rs2_address    (idRs2),
    .ID_Rs1_data       (idRs1Data),
    .ID_Rs2_data       (idRs2Data),
    .MEM_Rd_address    (memRd),
    .MEM_Rd_wr_en      (memWr),
    .MEM_ALU_result    (memRes),
    .WB_Rd_address     (wbRd),
    .WB_wr_en          (wbWr),
    .WB_Rd_wr_data     (wbData),
    .EX_stall          (exStall),
    .EX_flush          (exFlush),
    .EX_ALU_result     (exAluResult),
    .EX_Rs2_data       (exRs2Data),
    .EX_Rd_address     (exRdAddress),
    .EX_Rd_wr_en       (exRdWrEn),
    .EX_PC_branch_dest (exBranchDest),
    .EX_PC_source_sel  (exPcSourceSel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one EX instruction from the current input values.
  function automatic expT model();
    expT         e;
    logic [31:0] a;
    logic [31:0] r2;
    logic [31:0] b;
    logic        cond;
    a  = idRs1Data;
    r2 = idRs2Data;
`ifdef RV32I_EX_FWD_EN
    if (idRs1 != 5'd0) begin
      if (memWr && memRd == idRs1) a = memRes;
      else if (wbWr && wbRd == idRs1) a = wbData;
    end
    if (idRs2 != 5'd0) begin
      if (memWr && memRd == idRs2) r2 = memRes;
      else if (wbWr && wbRd == idRs2) r2 = wbData;
    end
`endif
    b    = (idOp < 4'd10 && idSrcSel) ? idImm : r2;
    cond = 1'b0;
    e    = '0;
    case (idOp)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a - b;
      4'd2:  e.res = a << b[4:0];
      4'd3:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd5:  e.res = a ^ b;
      4'd6:  e.res = a >> b[4:0];
      4'd7:  e.res = $signed(a) >>> b[4:0];
      4'd8:  e.res = a | b;
      4'd9:  e.res = a & b;
      4'd10: cond = (a == r2);
      4'd11: cond = (a != r2);
      4'd12: cond = ($signed(a) < $signed(r2));
      4'd13: cond = ($signed(a) >= $signed(r2));
      4'd14: cond = (a < r2);
      default: cond = (a >= r2);
    endcase
    e.rs2   = r2;
    e.rd    = idRd;
    e.wrEn  = idRdWrEn;
    e.dest  = idPc + idImm;
    e.taken = idBrEn & cond;
    return e;
  endfunction

  task automatic applyStimulus(input string tag);
    expT e;
    if (exFlush)      e = '0;
    else if (exStall) e = lastExp;
    else              e = model();
    lastExp = e;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    e = scoreboard.pop_front();
    checkOutput({tag, ".res"},   exAluResult,            e.res);
    checkOutput({tag, ".rs2"},   exRs2Data,              e.rs2);
    checkOutput({tag, ".rd"},    {27'd0, exRdAddress},   {27'd0, e.rd});
    checkOutput({tag, ".wrEn"},  {31'd0, exRdWrEn},      {31'd0, e.wrEn});
    checkOutput({tag, ".dest"},  exBranchDest,           e.dest);
    checkOutput({tag, ".taken"}, {31'd0, exPcSourceSel}, {31'd0, e.taken});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".res"},   exAluResult, 32'd0);
    checkOutput({tag, ".rs2"},   exRs2Data, 32'd0);
    checkOutput({tag, ".rd"},    {27'd0, exRdAddress}, 32'd0);
    checkOutput({tag, ".wrEn"},  {31'd0, exRdWrEn}, 32'd0);
    checkOutput({tag, ".dest"},  exBranchDest, 32'd0);
    checkOutput({tag, ".taken"}, {31'd0, exPcSourceSel}, 32'd0);
  endtask

  task automatic setQuiet();
    idPc = 32'h0; idRdWrEn = 1'b1; idSrcSel = 1'b0; idOp = 4'd0; idImm = 32'h0;
    idBrEn = 1'b0; idRd = 5'd5; idRs1 = 5'd1; idRs2 = 5'd2;
    idRs1Data = 32'h0; idRs2Data = 32'h0;
    memRd = 5'd0; memWr = 1'b0; memRes = 32'h0;
    wbRd = 5'd0; wbWr = 1'b0; wbData = 32'h0;
    exStall = 1'b0; exFlush = 1'b0;
  endtask

  task automatic randomInputs();
    idPc = $urandom; idRdWrEn = 1'($urandom_range(0, 1)); idSrcSel = 1'($urandom_range(0, 1));
    idOp = 4'($urandom_range(0, 15)); idImm = $urandom; idBrEn = 1'($urandom_range(0, 1));
    idRd = 5'($urandom_range(0, 31)); idRs1 = 5'($urandom_range(0, 3)); idRs2 = 5'($urandom_range(0, 3));
    idRs1Data = $urandom; idRs2Data = $urandom;
    memRd = 5'($urandom_range(0, 3)); memWr = 1'($urandom_range(0, 1)); memRes = $urandom;
    wbRd = 5'($urandom_range(0, 3)); wbWr = 1'($urandom_range(0, 1)); wbData = $urandom;
  endtask

  initial begin
    rstN = 1'b1;
    setQuiet();
    #1 rstN = 1'b0;
    #2;
    checkAllZero("reset");
    @(negedge clk);
    rstN = 1'b1;

    // ADD without hazards.
    idRs1Data = 32'd5; idRs2Data = 32'd7; idOp = 4'd0;
    applyStimulus("add");
    checkOutput("addConst", exAluResult, 32'd12);

    // MEM and WB both write x3: MEM must win, then WB when MEM stops writing.
    idRs1 = 5'd3; idRs1Data = 32'h10; idSrcSel = 1'b1; idImm = 32'd1;
    memRd = 5'd3; memWr = 1'b1; memRes = 32'hAA;
    wbRd = 5'd3; wbWr = 1'b1; wbData = 32'hBB;
    applyStimulus("fwdMem");
`ifdef RV32I_EX_FWD_EN
    checkOutput("fwdMemConst", exAluResult, 32'hAB);
`endif
    memWr = 1'b0;
    applyStimulus("fwdWb");
`ifdef RV32I_EX_FWD_EN
    checkOutput("fwdWbConst", exAluResult, 32'hBC);
`endif

    // x0 must never be forwarded.
    idRs1 = 5'd0; idRs1Data = 32'd0; idImm = 32'd0;
    memRd = 5'd0; memWr = 1'b1; memRes = 32'hFF; wbWr = 1'b0;
    applyStimulus("x0");
    checkOutput("x0Const", exAluResult, 32'd0);

    // Signed vs unsigned branch on the same operands; immediate is ignored for branches.
    setQuiet();
    idBrEn = 1'b1; idOp = 4'd12; idRs1Data = 32'hFFFF_FFFF; idRs2Data = 32'd1;
    idSrcSel = 1'b1; idPc = 32'h100; idImm = 32'hFFFF_FFF8;
    applyStimulus("blt");
    checkOutput("bltTaken", {31'd0, exPcSourceSel}, 32'd1);
    checkOutput("bltDest", exBranchDest, 32'hF8);
    idOp = 4'd14;
    applyStimulus("bltu");
    checkOutput("bltuTaken", {31'd0, exPcSourceSel}, 32'd0);

    // Branch enable with a non-branch code never takes.
    idOp = 4'd0;
    applyStimulus("brEnAlu");

    setQuiet();
    idOp = 4'd7; idRs1Data = 32'h8000_0000; idSrcSel = 1'b1; idImm = 32'd33;
    applyStimulus("sra");
    checkOutput("sraConst", exAluResult, 32'hC000_0000);
    idOp = 4'd4; idRs1Data = 32'd1; idImm = 32'd2;
    applyStimulus("sltu");
    checkOutput("sltuConst", exAluResult, 32'd1);

    // Stall three cycles with changing inputs, then flush together with stall.
    for (int i = 0; i < 3; i++) begin
      randomInputs();
      exStall = 1'b1;
      applyStimulus("stall");
      checkOutput("stallHold", exAluResult, 32'd1);
    end
    randomInputs();
    exStall = 1'b1; exFlush = 1'b1;
    applyStimulus("flushStall");

    for (int i = 0; i < 40; i++) begin
      randomInputs();
      exStall = ($urandom_range(0, 7) == 0);
      exFlush = ($urandom_range(0, 9) == 0);
      applyStimulus("rand");
    end

    // Asynchronous reset mid-stream drops the pending result immediately.
    randomInputs();
    exStall = 1'b0; exFlush = 1'b0;
    idRdWrEn = 1'b1; idOp = 4'd8; idRs1Data = 32'h1234_5678;
    applyStimulus("preRst");
    #2 rstN = 1'b0;
    #1;
    checkAllZero("midRst");
    lastExp = '0;
    #2 rstN = 1'b1;
    applyStimulus("postRst");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
